video_rom_arbiter: RTL and testbench

Shares one 32-bit external ROM port (SDRAM controller front end) among three video fetch requesters: sprite C-ROM (CROM_ADDR/CR), fix S-ROM (SFIX_ADDR/SFIX_DATA) and LO ROM (LO_ROM_ADDR/LO_ROM_DATA). Sits between the LSPC/NEO-273 address side and the memory controller. Latches strobed requests, arbitrates by fixed priority, translates addresses into a flat byte space, and returns lane-selected data with a valid pulse.

---
 rtl/vrom_arb_pkg.sv | 19 +
 rtl/vrom_req_slot.sv | 48 ++++
 rtl/video_rom_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_video_rom_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vrom_arb_pkg.sv
// Shared requester indices, FSM encoding and lane helper for video_rom_arbiter.
package vrom_arb_pkg;

  localparam int NUM_REQ  = 3;
  localparam int REQ_CROM = 0;
  localparam int REQ_SFIX = 1;
  localparam int REQ_LO   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } arb_state_e;

  // Moves the addressed byte lane down to bit 0; callers truncate to their width.
  function automatic logic [31:0] lane_select(input logic [31:0] word, input logic [1:0] lane);
    return word >> {lane, 3'b000};
  endfunction

endpackage

// File: rtl/vrom_req_slot.sv
// Single-entry request latch for one fetch requester: holds the latest strobed
// address until the arbiter issues it, flagging a lost request on overwrite.
module vrom_req_slot
  import vrom_arb_pkg::*;
#(
  parameter int AW = 27
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          strobe_i,
  input  logic          issue_i,
  input  logic [AW-1:0] addr_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic          overrun_o
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;

  // issue_i consumes the held entry if present, otherwise the strobe itself.
  always_comb begin
    valid_d   = valid_q;
    addr_d    = addr_q;
    overrun_o = 1'b0;
    if (strobe_i) begin
      addr_d    = addr_i;
      valid_d   = !(issue_i && !valid_q);
      overrun_o = valid_q && !issue_i;
    end else if (issue_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/video_rom_arbiter.sv
// Fixed-priority arbiter sharing one 32-bit ROM port among C-ROM, S-ROM and LO ROM
// fetches. Optional per-requester last-word cache: define VROM_ARB_CACHE_EN.
module video_rom_arbiter
  import vrom_arb_pkg::*;
#(
  parameter int                MEM_AW    = 27,
  parameter logic [MEM_AW-1:0] CROM_BASE = 27'h0000000,
  parameter logic [MEM_AW-1:0] SFIX_BASE = 27'h4000000,
  parameter logic [MEM_AW-1:0] LO_BASE   = 27'h4080000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CROM_REQ,
  input  logic [26:0]       CROM_ADDR,
  output logic [31:0]       CROM_DATA,
  output logic              CROM_VALID,
  input  logic              SFIX_REQ,
  input  logic [17:0]       SFIX_ADDR,
  output logic [15:0]       SFIX_DATA,
  output logic              SFIX_VALID,
  input  logic              LO_REQ,
  input  logic [15:0]       LO_ADDR,
  output logic [7:0]        LO_DATA,
  output logic              LO_VALID,
  output logic              MEM_REQ,
  output logic [MEM_AW-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [31:0]       MEM_DIN,
  output logic [2:0]        OVERRUN
);

  logic [NUM_REQ-1:0] strobe, slot_valid, slot_overrun, cur_valid;
  logic [NUM_REQ-1:0] issue, grant, cand, hit_serve, ack_hit;
  logic [MEM_AW-1:0]  raw_addr  [NUM_REQ];
  logic [MEM_AW-1:0]  slot_addr [NUM_REQ];
  logic [MEM_AW-1:0]  cur_addr  [NUM_REQ];

  arb_state_e         state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         lane_q, lane_d;
  logic               ack_fire;
  logic [NUM_REQ-1:0] valid_q, valid_d;
  logic [31:0]        crom_data_q, crom_data_d;
  logic [15:0]        sfix_data_q, sfix_data_d;
  logic [7:0]         lo_data_q, lo_data_d;
  logic [2:0]         overrun_q, overrun_d;

  assign strobe = {LO_REQ, SFIX_REQ, CROM_REQ};

  // Flat byte addresses; low bits survive into the lane select at issue.
  assign raw_addr[REQ_CROM] = CROM_BASE + MEM_AW'(CROM_ADDR & ~27'd3);
  assign raw_addr[REQ_SFIX] = SFIX_BASE + MEM_AW'({SFIX_ADDR, 1'b0});
  assign raw_addr[REQ_LO]   = LO_BASE + MEM_AW'(LO_ADDR);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    vrom_req_slot #(.AW(MEM_AW)) u_slot (
      .clk_i    (CLK),
      .reset_i  (RESET),
      .strobe_i (strobe[g]),
      .issue_i  (issue[g]),
      .addr_i   (raw_addr[g]),
      .valid_o  (slot_valid[g]),
      .addr_o   (slot_addr[g]),
      .overrun_o(slot_overrun[g])
    );
    // A strobe into an empty slot can be granted in the same cycle.
    assign cur_valid[g] = slot_valid[g] | strobe[g];
    assign cur_addr[g]  = slot_valid[g] ? slot_addr[g] : raw_addr[g];
    assign ack_hit[g]   = ack_fire && (owner_q == 2'(g));
  end

`ifdef VROM_ARB_CACHE_EN
  logic [NUM_REQ-1:0] tag_valid_q, cur_hit;
  logic [MEM_AW-3:0]  tag_addr_q [NUM_REQ];
  logic [31:0]        tag_data_q [NUM_REQ];

  // Hits are served only from a held slot so VALID lands two cycles after the
  // strobe, and never while the same requester still has a fetch outstanding.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_tag
    assign cur_hit[g]   = tag_valid_q[g] && (tag_addr_q[g] == cur_addr[g][MEM_AW-1:2]);
    assign cand[g]      = cur_valid[g] && !cur_hit[g];
    assign hit_serve[g] = slot_valid[g] && cur_hit[g] &&
                          !((state_q == ST_WAIT) && (owner_q == 2'(g)));
  end

  always_ff @(posedge CLK) begin
    for (int r = 0; r < NUM_REQ; r++) begin
      if (RESET) begin
        tag_valid_q[r] <= 1'b0;
        tag_addr_q[r]  <= '0;
        tag_data_q[r]  <= '0;
      end else if (ack_hit[r]) begin
        tag_valid_q[r] <= 1'b1;
        tag_addr_q[r]  <= mem_addr_q[MEM_AW-1:2];
        tag_data_q[r]  <= MEM_DIN;
      end
    end
  end
`else
  assign cand      = cur_valid;
  assign hit_serve = '0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    owner_d    = owner_q;
    lane_d     = lane_q;
    grant      = '0;
    ack_fire   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cand[REQ_CROM])      grant[REQ_CROM] = 1'b1;
        else if (cand[REQ_SFIX]) grant[REQ_SFIX] = 1'b1;
        else if (cand[REQ_LO])   grant[REQ_LO]   = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
          if (grant[r]) begin
            mem_req_d  = 1'b1;
            mem_addr_d = {cur_addr[r][MEM_AW-1:2], 2'b00};
            lane_d     = cur_addr[r][1:0];
            owner_d    = 2'(r);
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (MEM_ACK) begin
          ack_fire  = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue = grant | hit_serve;

  always_comb begin
    valid_d     = ack_hit | hit_serve;
    crom_data_d = crom_data_q;
    sfix_data_d = sfix_data_q;
    lo_data_d   = lo_data_q;
    if (ack_hit[REQ_CROM]) crom_data_d = MEM_DIN;
    if (ack_hit[REQ_SFIX]) sfix_data_d = 16'(lane_select(MEM_DIN, lane_q));
    if (ack_hit[REQ_LO])   lo_data_d   = 8'(lane_select(MEM_DIN, lane_q));
`ifdef VROM_ARB_CACHE_EN
    if (hit_serve[REQ_CROM]) crom_data_d = tag_data_q[REQ_CROM];
    if (hit_serve[REQ_SFIX])
      sfix_data_d = 16'(lane_select(tag_data_q[REQ_SFIX], cur_addr[REQ_SFIX][1:0]));
    if (hit_serve[REQ_LO])
      lo_data_d = 8'(lane_select(tag_data_q[REQ_LO], cur_addr[REQ_LO][1:0]));
`endif
    overrun_d = overrun_q | slot_overrun;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      owner_q     <= '0;
      lane_q      <= '0;
      valid_q     <= '0;
      crom_data_q <= '0;
      sfix_data_q <= '0;
      lo_data_q   <= '0;
      overrun_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      owner_q     <= owner_d;
      lane_q      <= lane_d;
      valid_q     <= valid_d;
      crom_data_q <= crom_data_d;
      sfix_data_q <= sfix_data_d;
      lo_data_q   <= lo_data_d;
      overrun_q   <= overrun_d;
    end
  end

  assign MEM_REQ    = mem_req_q;
  assign MEM_ADDR   = mem_addr_q;
  assign CROM_DATA  = crom_data_q;
  assign CROM_VALID = valid_q[REQ_CROM];
  assign SFIX_DATA  = sfix_data_q;
  assign SFIX_VALID = valid_q[REQ_SFIX];
  assign LO_DATA    = lo_data_q;
  assign LO_VALID   = valid_q[REQ_LO];
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_video_rom_arbiter.sv
// Directed bench for video_rom_arbiter with expected-address and expected-data queues.
module tb_video_rom_arbiter;

  localparam logic [26:0] SFIX_BASE = 27'h4000000;
  localparam logic [26:0] LO_BASE   = 27'h4080000;

  logic        CLK = 1'b0, RESET = 1'b1;
  logic        CROM_REQ = 1'b0, SFIX_REQ = 1'b0, LO_REQ = 1'b0, MEM_ACK = 1'b0;
  logic [26:0] CROM_ADDR = '0;
  logic [17:0] SFIX_ADDR = '0;
  logic [15:0] LO_ADDR = '0;
  logic [31:0] MEM_DIN = '0;
  logic [31:0] CROM_DATA;
  logic [15:0] SFIX_DATA;
  logic [7:0]  LO_DATA;
  logic        CROM_VALID, SFIX_VALID, LO_VALID, MEM_REQ;
  logic [26:0] MEM_ADDR;
  logic [2:0]  OVERRUN;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;
  exp_t        exp_q[$];
  logic [26:0] addr_q[$];

  video_rom_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .CROM_REQ(CROM_REQ), .CROM_ADDR(CROM_ADDR), .CROM_DATA(CROM_DATA), .CROM_VALID(CROM_VALID),
    .SFIX_REQ(SFIX_REQ), .SFIX_ADDR(SFIX_ADDR), .SFIX_DATA(SFIX_DATA), .SFIX_VALID(SFIX_VALID),
    .LO_REQ(LO_REQ), .LO_ADDR(LO_ADDR), .LO_DATA(LO_DATA), .LO_VALID(LO_VALID),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DIN(MEM_DIN),
    .OVERRUN(OVERRUN)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [15:0] exp_sfix(input logic [17:0] a, input logic [31:0] w);
    return a[0] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [7:0] exp_lo(input logic [15:0] a, input logic [31:0] w);
    case (a[1:0])
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // Drive a strobe; when 'track' is set, queue the memory address and returned data it implies.
  task automatic req_crom(input logic [26:0] a, input logic [31:0] w, input bit track, input bit to_mem);
    CROM_REQ = 1'b1; CROM_ADDR = a;
    if (track) exp_q.push_back('{0, w});
    if (track && to_mem) addr_q.push_back({a[26:2], 2'b00});
  endtask

  task automatic req_sfix(input logic [17:0] a, input logic [31:0] w, input bit track);
    logic [26:0] b;
    SFIX_REQ = 1'b1; SFIX_ADDR = a;
    b = SFIX_BASE + 27'({a, 1'b0});
    if (track) begin
      exp_q.push_back('{1, {16'h0, exp_sfix(a, w)}});
      addr_q.push_back({b[26:2], 2'b00});
    end
  endtask

  task automatic req_lo(input logic [15:0] a, input logic [31:0] w, input bit track);
    logic [26:0] b;
    LO_REQ = 1'b1; LO_ADDR = a;
    b = LO_BASE + 27'(a);
    if (track) begin
      exp_q.push_back('{2, {24'h0, exp_lo(a, w)}});
      addr_q.push_back({b[26:2], 2'b00});
    end
  endtask

  task automatic clear_req();
    CROM_REQ = 1'b0; SFIX_REQ = 1'b0; LO_REQ = 1'b0;
  endtask

  // Memory side: wait for a request, check its address, ack after 'delay' cycles.
  task automatic serve(input string tag, input logic [31:0] din, input int delay);
    logic [26:0] ea;
    int n;
    n = 0;
    while (MEM_REQ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, {31'h0, MEM_REQ}, 32'h1);
    ea = 'x;
    if (addr_q.size() != 0) ea = addr_q.pop_front();
    chk({tag, "_addr"}, {5'h0, MEM_ADDR}, {5'h0, ea});
    repeat (delay) tick();
    chk({tag, "_hold"}, {4'h0, MEM_REQ, MEM_ADDR}, {4'h0, 1'b1, ea});
    MEM_ACK = 1'b1; MEM_DIN = din;
    tick();
    MEM_ACK = 1'b0; MEM_DIN = '0;
    chk({tag, "_drop"}, {31'h0, MEM_REQ}, 32'h0);
  endtask

  task automatic check_valid(input int id, input logic [31:0] data);
    exp_t e;
    total++;
    assert (exp_q.size() != 0)
    else begin
      bad++;
      $error("FAIL unexpected_valid observed=id%0d expected=none", id);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("valid_owner", id, e.id);
      chk("valid_data", data, e.data);
    end
  endtask

  always @(negedge CLK) begin
    if (CROM_VALID === 1'b1) check_valid(0, CROM_DATA);
    if (SFIX_VALID === 1'b1) check_valid(1, {16'h0, SFIX_DATA});
    if (LO_VALID === 1'b1)   check_valid(2, {24'h0, LO_DATA});
  end

  initial begin
    repeat (3) tick();
    chk("rst_mem", {4'h0, MEM_REQ, MEM_ADDR}, 32'h0);
    chk("rst_valid", {29'h0, CROM_VALID, SFIX_VALID, LO_VALID}, 32'h0);
    chk("rst_data", CROM_DATA | {16'h0, SFIX_DATA} | {24'h0, LO_DATA}, 32'h0);
    chk("rst_overrun", {29'h0, OVERRUN}, 32'h0);
    RESET = 1'b0;
    tick();

    // single C-ROM fetch
    req_crom(27'h0001234, 32'hDEADBEEF, 1, 1);
    tick();
    clear_req();
    chk("crom_latency", {31'h0, MEM_REQ}, 32'h1);
    serve("crom1", 32'hDEADBEEF, 2);
    chk("crom_valid", {31'h0, CROM_VALID}, 32'h1);
    tick();
    chk("crom_pulse", {31'h0, CROM_VALID}, 32'h0);
    chk("crom_hold", CROM_DATA, 32'hDEADBEEF);

`ifdef VROM_ARB_CACHE_EN
    req_crom(27'h0001234, 32'hDEADBEEF, 1, 0);
    tick();
    clear_req();
    chk("cache_noreq", {31'h0, MEM_REQ}, 32'h0);
    chk("cache_early", {31'h0, CROM_VALID}, 32'h0);
    tick();
    chk("cache_valid", {31'h0, CROM_VALID}, 32'h1);
    chk("cache_data", CROM_DATA, 32'hDEADBEEF);
    tick();
`endif

    // S-ROM upper half and LO ROM byte lane 2
    req_sfix(18'h00003, 32'hAAAA5555, 1);
    tick();
    clear_req();
    serve("sfix1", 32'hAAAA5555, 1);
    chk("sfix_data", {16'h0, SFIX_DATA}, 32'h0000AAAA);
    tick();
    req_lo(16'h0002, 32'h11223344, 1);
    tick();
    clear_req();
    serve("lo1", 32'h11223344, 1);
    chk("lo_data", {24'h0, LO_DATA}, 32'h00000022);
    tick();

    // simultaneous strobes, ignored C-ROM low bits, top-of-range S-ROM/LO addresses
    req_crom(27'h0000103, 32'hCAFEF00D, 1, 1);
    req_sfix(18'h3FFFF, 32'h5A5A1234, 1);
    req_lo(16'hFFFF, 32'h99887766, 1);
    tick();
    clear_req();
    serve("pri_crom", 32'hCAFEF00D, 0);
    chk("b2b_gap", {31'h0, MEM_REQ}, 32'h0);
    tick();
    chk("b2b_sfix", {31'h0, MEM_REQ}, 32'h1);
    serve("pri_sfix", 32'h5A5A1234, 0);
    tick();
    chk("b2b_lo", {31'h0, MEM_REQ}, 32'h1);
    serve("pri_lo", 32'h99887766, 0);
    chk("pri_overrun", {29'h0, OVERRUN}, 32'h0);
    tick();

    // two LO strobes while C-ROM is outstanding: first one lost
    req_crom(27'h0002000, 32'h01020304, 1, 1);
    tick();
    clear_req();
    req_lo(16'h0010, 32'h0, 0);
    tick();
    req_lo(16'h0021, 32'hA1B2C3D4, 1);
    tick();
    clear_req();
    chk("overrun_lo", {29'h0, OVERRUN}, 32'h4);
    serve("ovr_crom", 32'h01020304, 1);
    serve("ovr_lo", 32'hA1B2C3D4, 1);
    chk("ovr_lo_data", {24'h0, LO_DATA}, 32'h000000C3);
    tick();

    // reset mid-transaction with a pending slot, then a stray ack
    req_crom(27'h0003000, 32'h0, 0, 0);
    tick();
    clear_req();
    req_lo(16'h0040, 32'h0, 0);
    tick();
    clear_req();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("midrst_req", {31'h0, MEM_REQ}, 32'h0);
    chk("midrst_overrun", {29'h0, OVERRUN}, 32'h0);
    chk("midrst_data", CROM_DATA | {24'h0, LO_DATA}, 32'h0);
    MEM_ACK = 1'b1; MEM_DIN = 32'hFFFFFFFF;
    tick();
    MEM_ACK = 1'b0; MEM_DIN = '0;
    for (int i = 0; i < 4; i++) begin
      chk("stray_idle", {28'h0, MEM_REQ, CROM_VALID, SFIX_VALID, LO_VALID}, 32'h0);
      tick();
    end

    chk("exp_drained", exp_q.size(), 32'h0);
    chk("addr_drained", addr_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
